// File: rtl/vrased_pkg.sv
// Purpose: shared state encoding and violation-source indices for the VRASED reset controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package vrased_pkg;

  localparam int NUM_VIOL = 6;

  // Bit positions inside viol_req / cause_first / cause_acc
  localparam int VIOL_XSTACK     = 0;
  localparam int VIOL_AC         = 1;
  localparam int VIOL_ATOMICITY  = 2;
  localparam int VIOL_DMA_AC     = 3;
  localparam int VIOL_DMA_DETECT = 4;
  localparam int VIOL_DMA_XSTACK = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/vrased_cause_log.sv
// Purpose: post-mortem record of violation causes, episode count and restart failures.
// Latency: all outputs update on the clock edge after the qualifying strobe.
// Backpressure: none; strobes are accepted every cycle.
// Ports: viol_req   - raw per-monitor requests
//        episode    - a new violation episode starts this cycle
//        acc_upd    - fold viol_req into cause_acc this cycle
//        retry      - a restart timeout forced another reset
//        clr        - qualified clear of every status register
module vrased_cause_log
  import vrased_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_VIOL-1:0] viol_req,
  input  logic                episode,
  input  logic                acc_upd,
  input  logic                retry,
  input  logic                clr,
  output logic [NUM_VIOL-1:0] cause_first,
  output logic [NUM_VIOL-1:0] cause_acc,
  output logic [CNT_W-1:0]    viol_cnt,
  output logic                restart_err
);

  // clr is only raised when no request is present, so it never competes
  // with episode/acc_upd in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_first <= '0;
      cause_acc   <= '0;
      viol_cnt    <= '0;
      restart_err <= 1'b0;
    end else if (clr) begin
      cause_first <= '0;
      cause_acc   <= '0;
      viol_cnt    <= '0;
      restart_err <= 1'b0;
    end else begin
      if (acc_upd) begin
        cause_acc <= cause_acc | viol_req;
      end
      if (episode) begin
        // Only the first episode since the last clear is snapshotted
        if (cause_first == '0) begin
          cause_first <= viol_req;
        end
        // Saturate rather than wrap so a flood of episodes stays visible
        if (viol_cnt != {CNT_W{1'b1}}) begin
          viol_cnt <= viol_cnt + 1'b1;
        end
      end
      if (retry) begin
        restart_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vrased_rst_ctrl.sv
// Purpose: drive CPU reset from VRASED monitor requests, stretch it, and confirm restart at the handler.
// Latency: cpu_rst follows viol_req combinationally (zero cycles); stretch lasts HOLD_CYCLES after the last request.
// Backpressure: none; requests are never stalled, a request during the stretch simply restarts it.
// Ports: clk, reset_n (async active-low), viol_req[5:0], pc[15:0], cause_clr in;
//        cpu_rst, busy, cause_first, cause_acc, viol_cnt, restart_err out.
module vrased_rst_ctrl
  import vrased_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          TIMEOUT       = 16,
  parameter int          CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_VIOL-1:0] viol_req,
  input  logic [15:0]         pc,
  input  logic                cause_clr,
  output logic                cpu_rst,
  output logic                busy,
  output logic [NUM_VIOL-1:0] cause_first,
  output logic [NUM_VIOL-1:0] cause_acc,
  output logic [CNT_W-1:0]    viol_cnt,
  output logic                restart_err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [WW-1:0] wait_cnt, wait_d;
  logic          any_req;
  logic          hold_q;
  logic          episode;
  logic          retry;
  logic          clr;

  assign any_req = |viol_req;
  assign hold_q  = (state_q == HOLD);
  assign busy    = (state_q != IDLE);
  // Combinational path so the CPU is held in reset in the very cycle a
  // violation is flagged; the registered term provides the stretch.
  assign cpu_rst = any_req | hold_q;
  assign clr     = cause_clr && (state_q == IDLE) && !any_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hold_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
      wait_cnt <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    wait_d  = wait_cnt;
    episode = 1'b0;
    retry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          episode = 1'b1;
        end
      end
      HOLD: begin
        // A repeat request while already resetting extends the stretch only
        if (any_req) begin
          hold_d = HOLD_LOAD;
        end else if (hold_cnt == '0) begin
          state_d = WAIT;
          wait_d  = '0;
        end else begin
          hold_d = hold_cnt - 1'b1;
        end
      end
      WAIT: begin
        if (any_req) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          episode = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_d = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          // CPU never reached the handler: reset it again, flag it, but do
          // not count it as a fresh violation episode
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          retry   = 1'b1;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  vrased_cause_log #(
    .CNT_W(CNT_W)
  ) u_cause_log (
    .clk        (clk),
    .reset_n    (reset_n),
    .viol_req   (viol_req),
    .episode    (episode),
    .acc_upd    (any_req),
    .retry      (retry),
    .clr        (clr),
    .cause_first(cause_first),
    .cause_acc  (cause_acc),
    .viol_cnt   (viol_cnt),
    .restart_err(restart_err)
  );

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// Purpose: self-checking bench for vrased_rst_ctrl using per-cycle and status expectation queues.
// Latency: n/a.
// Backpressure: n/a.
module tb_vrased_rst_ctrl;
  import vrased_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  viol_req = '0;
  logic [15:0] pc = 16'h1234;
  logic        cause_clr = 1'b0;
  logic        cpu_rst, busy, restart_err;
  logic [5:0]  cause_first, cause_acc;
  logic [7:0]  viol_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic rst;
    logic bsy;
  } cyc_exp_t;

  typedef struct packed {
    logic [5:0] first;
    logic [5:0] acc;
    logic [7:0] cnt;
    logic       err;
  } stat_exp_t;

  cyc_exp_t  cyc_q[$];
  stat_exp_t stat_q[$];

  localparam logic [15:0] PC_OFF = 16'hE000;
  localparam logic [15:0] PC_RH  = 16'h0000;

  vrased_rst_ctrl #(
    .RESET_HANDLER(16'h0000),
    .HOLD_CYCLES  (4),
    .TIMEOUT      (16),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .viol_req   (viol_req),
    .pc         (pc),
    .cause_clr  (cause_clr),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .cause_first(cause_first),
    .cause_acc  (cause_acc),
    .viol_cnt   (viol_cnt),
    .restart_err(restart_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, record what cpu_rst
  // and busy must be during this cycle, then compare mid-cycle.
  task automatic cyc(input logic [5:0] v, input logic [15:0] p, input logic c,
                     input logic er, input logic eb);
    cyc_exp_t e;
    @(posedge clk);
    #1;
    viol_req  = v;
    pc        = p;
    cause_clr = c;
    cyc_q.push_back('{rst: er, bsy: eb});
    @(negedge clk);
    e = cyc_q.pop_front();
    check("cpu_rst", 32'(cpu_rst), 32'(e.rst));
    check("busy", 32'(busy), 32'(e.bsy));
  endtask

  task automatic status(input logic [5:0] f, input logic [5:0] a,
                        input logic [7:0] n, input logic err);
    stat_exp_t e;
    stat_q.push_back('{first: f, acc: a, cnt: n, err: err});
    e = stat_q.pop_front();
    check("cause_first", 32'(cause_first), 32'(e.first));
    check("cause_acc", 32'(cause_acc), 32'(e.acc));
    check("viol_cnt", 32'(viol_cnt), 32'(e.cnt));
    check("restart_err", 32'(restart_err), 32'(e.err));
  endtask

  // IDLE cycle with a clear pulse, then confirm everything reads zero
  task automatic clear_all();
    cyc(6'd0, PC_OFF, 1'b1, 1'b0, 1'b0);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'd0, 6'd0, 8'd0, 1'b0);
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(6'd0, PC_OFF, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset state, including combinational cpu_rst while in reset
    #2;
    check("rst_cpu_rst_idle", 32'(cpu_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    status(6'd0, 6'd0, 8'd0, 1'b0);
    viol_req = 6'b000001;
    #1;
    check("rst_cpu_rst_comb", 32'(cpu_rst), 32'd1);
    check("rst_busy_held", 32'(busy), 32'd0);
    viol_req = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single AC pulse, handler reached on the 2nd WAIT cycle
    cyc(6'b000010, PC_OFF, 1'b0, 1'b1, 1'b0);
    hold_cycles(4);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b1);
    cyc(6'd0, PC_RH, 1'b0, 1'b0, 1'b1);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'b000010, 6'b000010, 8'd1, 1'b0);

    // 2: second request in the 2nd HOLD cycle reloads the stretch
    clear_all();
    cyc(6'b000010, PC_OFF, 1'b0, 1'b1, 1'b0);
    hold_cycles(1);
    cyc(6'b100000, PC_OFF, 1'b0, 1'b1, 1'b1);
    hold_cycles(4);
    cyc(6'd0, PC_RH, 1'b0, 1'b0, 1'b1);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'b000010, 6'b100010, 8'd1, 1'b0);

    // 3: WAIT timeout after 16 cycles forces a retry
    clear_all();
    cyc(6'b000010, PC_OFF, 1'b0, 1'b1, 1'b0);
    hold_cycles(4);
    for (int i = 0; i < 16; i++) cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b1);
    hold_cycles(1);
    status(6'b000010, 6'b000010, 8'd1, 1'b1);
    hold_cycles(3);
    cyc(6'd0, PC_RH, 1'b0, 1'b0, 1'b1);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'b000010, 6'b000010, 8'd1, 1'b1);

    // 4: atomicity request in the first WAIT cycle is a new episode
    clear_all();
    cyc(6'b000010, PC_OFF, 1'b0, 1'b1, 1'b0);
    hold_cycles(4);
    cyc(6'b000100, PC_OFF, 1'b0, 1'b1, 1'b1);
    hold_cycles(4);
    cyc(6'd0, PC_RH, 1'b0, 1'b0, 1'b1);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'b000010, 6'b000110, 8'd2, 1'b0);

    // 5: 300 episodes saturate the counter; clear while HOLD is ignored
    clear_all();
    for (int i = 0; i < 300; i++) begin
      logic [5:0] v;
      v = 6'b000001 << (i % 6);
      cyc(v, PC_OFF, 1'b0, 1'b1, 1'b0);
      cyc(6'd0, PC_OFF, 1'b1, 1'b1, 1'b1);
      hold_cycles(3);
      cyc(6'd0, PC_RH, 1'b0, 1'b0, 1'b1);
    end
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'b000001, 6'b111111, 8'd255, 1'b0);
    clear_all();
    // Clear together with a request: the violation wins
    cyc(6'b000001, PC_OFF, 1'b1, 1'b1, 1'b0);
    hold_cycles(1);
    status(6'b000001, 6'b000001, 8'd1, 1'b0);
    hold_cycles(3);
    cyc(6'd0, PC_RH, 1'b0, 1'b0, 1'b1);

    // 6: reset_n dropped mid-HOLD aborts immediately
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    cyc(1 << VIOL_DMA_AC, PC_OFF, 1'b0, 1'b1, 1'b0);
    hold_cycles(2);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hold_q", 32'(dut.hold_q), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd0);
    status(6'd0, 6'd0, 8'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    cyc(6'd0, PC_OFF, 1'b0, 1'b0, 1'b0);
    status(6'd0, 6'd0, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vrased_rst_ctrl.md
Name: vrased_rst_ctrl

Overview:
- Consumer end of the VRASED violation-reset path.
- Takes the six per-monitor reset requests and drives the CPU reset with zero added latency.
- Stretches the reset for a minimum hold time, then confirms the CPU actually restarts at RESET_HANDLER, retrying on timeout.
- Records first and accumulated violation causes plus a saturating episode counter for post-mortem readout by trusted code.

Parameters:
- RESET_HANDLER, 16'h0000, PC value that proves the CPU restarted.
- HOLD_CYCLES, 4, minimum cycles the registered reset stays high; must be ≥1.
- TIMEOUT, 16, cycles allowed in WAIT for the fetch at RESET_HANDLER before retry; must be ≥1.
- CNT_W, 8, width of the violation episode counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, active-low
- viol_req  in  6  reset requests. Bit 0 X_stack, 1 AC, 2 atomicity, 3 dma_AC, 4 dma_detect, 5 dma_X_stack.
- pc  in  16  current CPU program counter
- cause_clr  in  1  single-cycle clear of the cause/status outputs
- cpu_rst  out  1  active-high reset to the CPU
- busy  out  1  state != IDLE
- cause_first  out  6  viol_req snapshot of the first episode since the last clear
- cause_acc  out  6  OR of every viol_req bit seen since the last clear
- viol_cnt  out  CNT_W  number of episodes, saturating
- restart_err  out  1  sticky; set when a WAIT timeout forces a retry

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous, active-low.
- While reset_n is low:
  - state = IDLE; hold_q, counters and all registered outputs = 0.
  - cpu_rst still follows viol_req combinationally.
- cpu_rst = (|viol_req) | hold_q.
  - Combinational term: a violation resets the CPU in the same cycle it is flagged.
  - hold_q is high exactly in state HOLD.
- State IDLE:
  - If |viol_req: go to HOLD and load hold_cnt = HOLD_CYCLES-1.
  - This is a new episode: viol_cnt +1, cause_acc |= viol_req.
  - cause_first <= viol_req only if cause_first == 0.
- State HOLD:
  - If |viol_req: reload hold_cnt = HOLD_CYCLES-1 and cause_acc |= viol_req. This is not a new episode: no count change, no cause_first change.
  - Else if hold_cnt == 0: go to WAIT and clear wait_cnt.
  - Else: hold_cnt decrements.
  - With HOLD_CYCLES=4 and no further requests, hold_q is high for exactly 4 cycles.
- State WAIT (cpu_rst driven only by the combinational term):
  - If |viol_req: go to HOLD as a new episode (count +1, cause_acc updated). Takes priority over the pc check.
  - Else if pc == RESET_HANDLER: go to IDLE.
  - Else if wait_cnt == TIMEOUT-1: go to HOLD, set restart_err, reload hold_cnt. Not counted as an episode.
  - Else: wait_cnt increments.
- viol_cnt saturates at all-ones; it never wraps.
- cause_clr:
  - Honoured only in IDLE with viol_req == 0. Clears cause_first, cause_acc, viol_cnt and restart_err.
  - Ignored in HOLD/WAIT.
  - In IDLE with a simultaneous viol_req, the violation wins: the episode is captured and the clear is dropped.
- A reset_n assertion in mid-HOLD or mid-WAIT aborts immediately to the reset values.

Decomposition:
- Shared package vrased_pkg:
  - state encoding (IDLE=2'd0, HOLD=2'd1, WAIT=2'd2)
  - viol_req bit-index constants (VIOL_XSTACK..VIOL_DMA_XSTACK)
  - NUM_VIOL=6
- One natural sub-module: vrased_cause_log. It holds cause_first, cause_acc, viol_cnt, restart_err and the clear logic, driven by an episode strobe from the FSM.
- The FSM and the hold/wait counters stay in the top.

Test Plan:
- Pulse viol_req=6'b000010 for 1 cycle from IDLE, with pc reaching 16'h0000 2 cycles after HOLD exits.
  - cpu_rst high in the request cycle, then for 4 more cycles.
  - Then WAIT for 2 cycles, then IDLE.
  - cause_first=cause_acc=6'b000010, viol_cnt=1.
- Second request 6'b100000 in the 2nd HOLD cycle.
  - hold reloads (cpu_rst stays high 4 cycles after it).
  - cause_acc=6'b100010, cause_first=6'b000010, viol_cnt=1.
- In WAIT, hold pc at 16'hE000.
  - After 16 WAIT cycles the FSM returns to HOLD with restart_err=1.
  - viol_cnt is unchanged.
- Request 6'b000100 in the first WAIT cycle.
  - Same-cycle cpu_rst, back to HOLD, viol_cnt increments, cause_acc gains bit 2.
- Issue 300 episodes with CNT_W=8: viol_cnt saturates at 255.
  - Then cause_clr in IDLE zeroes all status.
  - Then cause_clr together with viol_req=6'b000001: cause_first=6'b000001, viol_cnt=1.
- Drop reset_n mid-HOLD: busy and hold_q fall immediately; after release the FSM is in IDLE with zeroed status.
